tcu_drl_align_acc: RTL and testbench

Pipelined align-and-accumulate stage directly downstream of the DRL multiply/exponent stage. Takes the per-lane raw significands (TCK products plus the C term), right-shifts each by its shift amount relative to the shared maximum exponent, zeroes masked lanes, and sums all terms into one signed wide accumulator. Two pipeline stages with valid/ready backpressure. `max_exp`, exceptions and `req_id` travel alongside the data to the normalize/round stage.

---
 rtl/tcu_drl_align_acc_pkg.sv | 23 ++
 rtl/tcu_drl_align_acc_if.sv | 56 +++++
 rtl/tcu_drl_align_lane.sv | 47 ++++
 rtl/tcu_drl_align_acc.sv | 139 +++++++++++++
 tb/tb_tcu_drl_align_acc.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcu_drl_align_acc_pkg.sv
// Shared TCU definitions used by the DRL align/accumulate slice.
//   fedp_excep_t        : exception flags carried alongside every beat
//   TCU_DRL_GUARD_BITS  : default number of guard bits below the significand LSB
//   tcu_drl_acc_width() : width of an exact signed sum of `terms` aligned values
package tcu_drl_align_acc_pkg;

  typedef struct packed {
    logic invalid;
    logic div_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fedp_excep_t;

  localparam int TCU_DRL_GUARD_BITS = 3;

  // Each aligned term is a (w+g)-bit signed value; summing `terms` of them
  // needs clog2(terms) extra integer bits to be exact.
  function automatic int tcu_drl_acc_width(input int w, input int g, input int terms);
    return w + g + $clog2(terms);
  endfunction

endpackage

// File: rtl/tcu_drl_align_acc_if.sv
// Beat channel between the DRL multiply/exponent stage, the align/accumulate
// stage and the normalize/round stage.
//   slave  modport : the align/accumulate stage (consumes *_in, produces *_out)
//   master modport : the surrounding logic (produces *_in, consumes *_out)
// Input side : valid_in/ready_in, req_id_in, max_exp_in, shift_amt, raw_sigs,
//              lane_mask, exceptions_in
// Output side: valid_out/ready_out, req_id_out, max_exp_out, acc_sum,
//              exceptions_out, sticky (only when TCU_DRL_STICKY_EN is defined)
interface tcu_drl_align_acc_if
  import tcu_drl_align_acc_pkg::*;
#(
  parameter int TCK   = 4,
  parameter int W     = 25,
  parameter int EXP_W = 10,
  parameter int G     = TCU_DRL_GUARD_BITS
);
  localparam int SW = tcu_drl_acc_width(W, G, TCK + 1);

  logic                     valid_in;
  logic                     ready_in;
  logic [31:0]              req_id_in;
  logic [EXP_W-1:0]         max_exp_in;
  logic [TCK:0][7:0]        shift_amt;
  logic [TCK:0][W-1:0]      raw_sigs;
  logic [TCK-1:0]           lane_mask;
  fedp_excep_t              exceptions_in;

  logic                     valid_out;
  logic                     ready_out;
  logic [31:0]              req_id_out;
  logic [EXP_W-1:0]         max_exp_out;
  logic signed [SW-1:0]     acc_sum;
  fedp_excep_t              exceptions_out;
`ifdef TCU_DRL_STICKY_EN
  logic                     sticky;
`endif

  modport slave (
    input  valid_in, req_id_in, max_exp_in, shift_amt, raw_sigs, lane_mask,
           exceptions_in, ready_out,
    output ready_in, valid_out, req_id_out, max_exp_out, acc_sum, exceptions_out
`ifdef TCU_DRL_STICKY_EN
    , output sticky
`endif
  );

  modport master (
    output valid_in, req_id_in, max_exp_in, shift_amt, raw_sigs, lane_mask,
           exceptions_in, ready_out,
    input  ready_in, valid_out, req_id_out, max_exp_out, acc_sum, exceptions_out
`ifdef TCU_DRL_STICKY_EN
    , input sticky
`endif
  );

endinterface

// File: rtl/tcu_drl_align_lane.sv
// Combinational per-term alignment: appends G zero guard bits to a signed
// W-bit significand, arithmetic right-shifts it by `shift`, and forces the
// result to zero when the lane is disabled.
// Optional macro TCU_DRL_STICKY_EN adds the `sticky` output (OR of every bit
// discarded by the shift, zero for a disabled lane).
//   sig     : W-bit two's complement significand
//   shift   : right-shift amount
//   en      : lane enable (tie high for the C term)
//   aligned : (W+G)-bit signed aligned term
//   sticky  : discarded-bits indicator (TCU_DRL_STICKY_EN only)
module tcu_drl_align_lane #(
  parameter int W = 25,
  parameter int G = 3
) (
  input  logic [W-1:0]          sig,
  input  logic [7:0]            shift,
  input  logic                  en,
  output logic signed [W+G-1:0] aligned
`ifdef TCU_DRL_STICKY_EN
  , output logic                sticky
`endif
);
  localparam int WG = W + G;

  logic signed [WG-1:0] ext;
  logic                 shift_all;

  assign ext       = $signed({sig, {G{1'b0}}});
  // Shifting by the full width or more leaves only sign bits.
  assign shift_all = (shift >= 8'(WG));

  always_comb begin
    aligned = '0;
    if (en) begin
      if (shift_all) aligned = {WG{ext[WG-1]}};
      else           aligned = ext >>> shift;
    end
  end

`ifdef TCU_DRL_STICKY_EN
  logic [WG-1:0] drop_mask;

  assign drop_mask = shift_all ? '1 : ~({WG{1'b1}} << shift);
  assign sticky    = en && (|(ext & drop_mask));
`endif

endmodule

// File: rtl/tcu_drl_align_acc.sv
// Align-and-accumulate stage following the DRL multiply/exponent stage.
// Aligns TCK product terms plus the C term to the shared maximum exponent,
// zeroes masked product lanes and sums all terms exactly into a signed
// SW-bit accumulator. Two registered stages with valid/ready backpressure;
// req_id, max_exp and exceptions travel unchanged beside the data.
// Optional macro TCU_DRL_STICKY_EN adds the `sticky` output and its logic.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : tcu_drl_align_acc_if.slave beat channel (input and output sides)
module tcu_drl_align_acc
  import tcu_drl_align_acc_pkg::*;
#(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int W     = 25,
  parameter int EXP_W = 10,
  parameter int G     = TCU_DRL_GUARD_BITS
) (
  input logic                 clk,
  input logic                 reset_n,
  tcu_drl_align_acc_if.slave  bus
);
  localparam int T  = TCK + 1;
  localparam int WG = W + G;
  localparam int SW = tcu_drl_acc_width(W, G, T);
  localparam int LEVELS = (T > 1) ? $clog2(T) : 1;

  // Balanced pairwise adder tree over sign-extended aligned terms.
  function automatic logic signed [SW-1:0] tree_sum(input logic signed [WG-1:0] terms [T]);
    logic signed [SW-1:0] lvl [T];
    for (int i = 0; i < T; i++) lvl[i] = SW'(terms[i]);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < T; i++) begin
        if (2 * i + 1 < T)  lvl[i] = lvl[2 * i] + lvl[2 * i + 1];
        else if (2 * i < T) lvl[i] = lvl[2 * i];
        else                lvl[i] = '0;
      end
    end
    return lvl[0];
  endfunction

  logic                 s2_advance;
  logic                 s1_load;
  logic                 s2_load;
  logic [T-1:0]         lane_en;
  logic signed [WG-1:0] lane_a [T];

  logic                 vld_p1;
  logic signed [WG-1:0] a_p1 [T];
  logic [31:0]          req_id_p1;
  logic [EXP_W-1:0]     max_exp_p1;
  fedp_excep_t          exc_p1;

  logic                 vld_p2;
  logic signed [SW-1:0] acc_p2;
  logic [31:0]          req_id_p2;
  logic [EXP_W-1:0]     max_exp_p2;
  fedp_excep_t          exc_p2;

`ifdef TCU_DRL_STICKY_EN
  logic [T-1:0]         lane_sticky;
  logic                 sticky_p1;
  logic                 sticky_p2;
`endif

  // The C term (index TCK) can never be masked.
  assign lane_en = {1'b1, bus.lane_mask};

  for (genvar i = 0; i < T; i++) begin : g_lane
    tcu_drl_align_lane #(.W(W), .G(G)) u_lane (
      .sig     (bus.raw_sigs[i]),
      .shift   (bus.shift_amt[i]),
      .en      (lane_en[i]),
      .aligned (lane_a[i])
`ifdef TCU_DRL_STICKY_EN
      , .sticky(lane_sticky[i])
`endif
    );
  end

  // An empty stage 2 always advances, so bubbles collapse.
  assign s2_advance   = !vld_p2 || bus.ready_out;
  assign bus.ready_in = !vld_p1 || s2_advance;
  assign s1_load      = bus.valid_in && bus.ready_in;
  assign s2_load      = vld_p1 && s2_advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      for (int i = 0; i < T; i++) a_p1[i] <= '0;
      req_id_p1  <= '0;
      max_exp_p1 <= '0;
      exc_p1     <= '0;
      acc_p2     <= '0;
      req_id_p2  <= '0;
      max_exp_p2 <= '0;
      exc_p2     <= '0;
`ifdef TCU_DRL_STICKY_EN
      sticky_p1  <= 1'b0;
      sticky_p2  <= 1'b0;
`endif
    end else begin
      // ---- stage 1: aligned terms ----
      if (bus.ready_in) vld_p1 <= bus.valid_in;
      if (s1_load) begin
        a_p1       <= lane_a;
        req_id_p1  <= bus.req_id_in;
        max_exp_p1 <= bus.max_exp_in;
        exc_p1     <= bus.exceptions_in;
`ifdef TCU_DRL_STICKY_EN
        sticky_p1  <= |lane_sticky;
`endif
      end
      // ---- stage 2: accumulated sum ----
      if (s2_advance) vld_p2 <= vld_p1;
      if (s2_load) begin
        acc_p2     <= tree_sum(a_p1);
        req_id_p2  <= req_id_p1;
        max_exp_p2 <= max_exp_p1;
        exc_p2     <= exc_p1;
`ifdef TCU_DRL_STICKY_EN
        sticky_p2  <= sticky_p1;
`endif
      end
    end
  end

  assign bus.valid_out      = vld_p2;
  assign bus.acc_sum        = acc_p2;
  assign bus.req_id_out     = req_id_p2;
  assign bus.max_exp_out    = max_exp_p2;
  assign bus.exceptions_out = exc_p2;
`ifdef TCU_DRL_STICKY_EN
  assign bus.sticky         = sticky_p2;
`endif

endmodule

// File: tb/tb_tcu_drl_align_acc.sv
// Self-checking bench for tcu_drl_align_acc: directed scenarios, a
// backpressure stream, randomized traffic against a arithmetic reference
// model, and an asynchronous reset with both stages full.
// Sticky checks are present only when TCU_DRL_STICKY_EN is defined.
module tb_tcu_drl_align_acc;
  import tcu_drl_align_acc_pkg::*;

  localparam int TCK   = 4;
  localparam int W     = 25;
  localparam int EXP_W = 10;
  localparam int G     = 3;
  localparam int SW    = tcu_drl_acc_width(W, G, TCK + 1);

  typedef struct {
    logic [63:0]      sum;
    logic             stk;
    logic [31:0]      id;
    logic [EXP_W-1:0] me;
    fedp_excep_t      ex;
  } exp_t;

  logic clk;
  logic reset_n;

  tcu_drl_align_acc_if #(.TCK(TCK), .W(W), .EXP_W(EXP_W), .G(G)) bus ();

  tcu_drl_align_acc #(.N(2), .W(W), .EXP_W(EXP_W), .G(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   delivered = 0;
  bit   last_in_fire = 0;
  bit   stall_pend = 0;
  logic [63:0] snap_acc;
  logic [31:0] snap_id;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] sx(input logic [SW-1:0] v);
    return {{(64 - SW){v[SW-1]}}, v};
  endfunction

  // Reference: each term is raw * 2^G divided by 2^shift with rounding
  // toward minus infinity; any nonzero remainder means bits were lost.
  function automatic exp_t model_beat();
    exp_t   e;
    longint sum;
    bit     stk;
    sum = 0;
    stk = 0;
    for (int i = 0; i <= TCK; i++) begin
      longint v, d, qt, r;
      int     s;
      v  = longint'($signed(bus.raw_sigs[i])) * (longint'(1) << G);
      s  = int'(bus.shift_amt[i]);
      if (s > 40) s = 40;
      d  = longint'(1) << s;
      qt = v / d;
      r  = v % d;
      if (r != 0 && v < 0) qt = qt - 1;
      if (i == TCK || bus.lane_mask[i]) begin
        sum = sum + qt;
        if (r != 0) stk = 1;
      end
    end
    e.sum = sum;
    e.stk = stk;
    e.id  = bus.req_id_in;
    e.me  = bus.max_exp_in;
    e.ex  = bus.exceptions_in;
    return e;
  endfunction

  // One clock cycle: sample handshakes before the edge, score deliveries,
  // record accepted beats, then advance to the next falling edge.
  task automatic tick();
    bit   in_f, out_f;
    exp_t e;
    #1;
    if (stall_pend) begin
      check("stall_valid", 64'(bus.valid_out), 64'd1);
      check("stall_acc", sx(bus.acc_sum), snap_acc);
      check("stall_id", 64'(bus.req_id_out), 64'(snap_id));
      stall_pend = 0;
    end
    in_f  = bus.valid_in && bus.ready_in;
    out_f = bus.valid_out && bus.ready_out;
    if (out_f) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(bus.valid_out), 64'd0);
      end else begin
        e = q.pop_front();
        check("out_acc", sx(bus.acc_sum), e.sum);
        check("out_id", 64'(bus.req_id_out), 64'(e.id));
        check("out_max_exp", 64'(bus.max_exp_out), 64'(e.me));
        check("out_exc", 64'(bus.exceptions_out), 64'(e.ex));
`ifdef TCU_DRL_STICKY_EN
        check("out_sticky", 64'(bus.sticky), 64'(e.stk));
`endif
        delivered++;
      end
    end else if (bus.valid_out) begin
      stall_pend = 1;
      snap_acc   = sx(bus.acc_sum);
      snap_id    = bus.req_id_out;
    end
    if (in_f) q.push_back(model_beat());
    last_in_fire = in_f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_zero();
    bus.raw_sigs      = '0;
    bus.shift_amt     = '0;
    bus.lane_mask     = '1;
    bus.max_exp_in    = '0;
    bus.exceptions_in = '0;
    bus.req_id_in     = '0;
  endtask

  task automatic rand_payload(input logic [31:0] id);
    for (int i = 0; i <= TCK; i++) begin
      int r;
      bus.raw_sigs[i] = W'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      bus.shift_amt[i] = 8'd255;
      else if (r == 1) bus.shift_amt[i] = 8'($urandom_range(28, 40));
      else             bus.shift_amt[i] = 8'($urandom_range(0, 27));
    end
    bus.lane_mask     = TCK'($urandom);
    bus.max_exp_in    = EXP_W'($urandom);
    bus.exceptions_in = fedp_excep_t'(5'($urandom));
    bus.req_id_in     = id;
  endtask

  // Present one beat with an idle downstream path and check 2-cycle latency;
  // the caller inspects the result and then calls tick() to deliver it.
  task automatic send_one(input logic [31:0] id);
    bus.req_id_in = id;
    bus.ready_out = 1'b1;
    bus.valid_in  = 1'b1;
    tick();
    bus.valid_in  = 1'b0;
    check("lat_cycle1_valid", 64'(bus.valid_out), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(bus.valid_out), 64'd1);
  endtask

  initial begin
    int sent;
    int d0;
    logic [31:0] id;

    clk     = 1'b0;
    reset_n = 1'b0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    set_zero();

    #3;
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_acc", sx(bus.acc_sum), 64'd0);
    check("rst_id", 64'(bus.req_id_out), 64'd0);
    check("rst_max_exp", 64'(bus.max_exp_out), 64'd0);
    check("rst_exc", 64'(bus.exceptions_out), 64'd0);
`ifdef TCU_DRL_STICKY_EN
    check("rst_sticky", 64'(bus.sticky), 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready_in", 64'(bus.ready_in), 64'd1);

    // Four unit products, C = 0.
    set_zero();
    for (int i = 0; i < TCK; i++) bus.raw_sigs[i] = W'(1);
    bus.max_exp_in    = 10'h155;
    bus.exceptions_in = fedp_excep_t'(5'b10101);
    send_one(32'd11);
    check("s1_acc", sx(bus.acc_sum), 64'd32);
`ifdef TCU_DRL_STICKY_EN
    check("s1_sticky", 64'(bus.sticky), 64'd0);
`endif
    tick();

    // Small shift keeps all bits.
    set_zero();
    bus.raw_sigs[0]  = W'(3);
    bus.shift_amt[0] = 8'd1;
    send_one(32'd12);
    check("s2_acc", sx(bus.acc_sum), 64'd12);
    tick();

    // Larger shift drops set bits.
    bus.shift_amt[0] = 8'd4;
    send_one(32'd13);
    tick();

    // Negative term shifted beyond the width leaves -1.
    set_zero();
    bus.raw_sigs[2]  = '1;
    bus.shift_amt[2] = 8'd40;
    send_one(32'd14);
    check("s3_acc", sx(bus.acc_sum), 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef TCU_DRL_STICKY_EN
    check("s3_sticky", 64'(bus.sticky), 64'd1);
`endif
    tick();

    // Same term masked off.
    bus.lane_mask = 4'b1011;
    send_one(32'd15);
    check("s3m_acc", sx(bus.acc_sum), 64'd0);
    tick();

    // Backpressure stream, ready_out pattern 1,0,0,1 repeating.
    sent = 0;
    d0   = delivered;
    rand_payload(32'd1);
    for (int cyc = 0; cyc < 80 && (sent < 5 || q.size() > 0); cyc++) begin
      bus.valid_in  = (sent < 5);
      bus.ready_out = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      tick();
      if (last_in_fire) begin
        sent++;
        if (sent < 5) rand_payload(32'(sent + 1));
      end
    end
    bus.valid_in = 1'b0;
    check("bp_queue_empty", 64'(q.size()), 64'd0);
    check("bp_delivered", 64'(delivered - d0), 64'd5);

    // Randomized traffic with random backpressure.
    id = 32'd1000;
    rand_payload(id);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.valid_in  = ($urandom_range(0, 3) != 0);
      bus.ready_out = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) begin
        id = id + 1;
        rand_payload(id);
      end
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) tick();
    check("rand_drained", 64'(q.size()), 64'd0);

    // Fill both stages, then reset asynchronously.
    bus.ready_out = 1'b0;
    bus.valid_in  = 1'b1;
    rand_payload(32'd300);
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (last_in_fire) rand_payload(32'd301);
    end
    check("full_valid_out", 64'(bus.valid_out), 64'd1);
    check("full_ready_in", 64'(bus.ready_in), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("mid_rst_acc", sx(bus.acc_sum), 64'd0);
    check("mid_rst_id", 64'(bus.req_id_out), 64'd0);
    check("mid_rst_exc", 64'(bus.exceptions_out), 64'd0);
`ifdef TCU_DRL_STICKY_EN
    check("mid_rst_sticky", 64'(bus.sticky), 64'd0);
`endif
    q.delete();
    stall_pend   = 0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_ready_in", 64'(bus.ready_in), 64'd1);
    rand_payload(32'd400);
    send_one(32'd400);
    check("rel_first_id", 64'(bus.req_id_out), 64'd400);
    tick();
    check("rel_queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
